// File: rtl/gs232c_iq_pkg.sv
// Shared constants for the instruction-queue read side: entry width default,
// pointer width (N+3, one wrap bit above the index) and capacity (4<<N).
package gs232c_iq_pkg;

    localparam int unsigned IQ_W     = 39;
    localparam int unsigned IQ_N     = 2;
    localparam int unsigned IQ_PTR_W = IQ_N + 3;
    localparam int unsigned IQ_CAP   = 4 << IQ_N;

    function automatic int unsigned ptr_width(input int unsigned n);
        return n + 3;
    endfunction

    function automatic int unsigned capacity(input int unsigned n);
        return 4 << n;
    endfunction

endpackage

// File: rtl/gs232c_iq_lane_compact.sv
// Next-state merge for the decode buffer: surviving lanes shift down by the
// accepted count, fresh queue lanes fill in behind them; unused lanes hold.
module gs232c_iq_lane_compact #(
    parameter int unsigned W = 39,
    parameter int unsigned M = 3
) (
    input  logic [W*M-1:0] cur_data,
    input  logic [W*M-1:0] q_data,
    input  logic [1:0]     acc,
    input  logic [1:0]     rem,
    input  logic [1:0]     load,
    output logic [W*M-1:0] nxt_data,
    output logic [M-1:0]   nxt_valid
);

    int unsigned a_i;
    int unsigned r_i;
    int unsigned l_i;

    // Source lanes are selected by equality search so no index can go out of range.
    always_comb begin
        a_i       = 32'(acc);
        r_i       = 32'(rem);
        l_i       = 32'(load);
        nxt_data  = cur_data;
        nxt_valid = '0;
        for (int unsigned i = 0; i < M; i++) begin
            if (i < r_i) begin
                for (int unsigned j = 0; j < M; j++) begin
                    if (j == i + a_i) nxt_data[i*W +: W] = cur_data[j*W +: W];
                end
            end else if (i < r_i + l_i) begin
                for (int unsigned j = 0; j < M; j++) begin
                    if (j + r_i == i) nxt_data[i*W +: W] = q_data[j*W +: W];
                end
            end
            nxt_valid[i] = (i < r_i + l_i);
        end
    end

endmodule

// File: rtl/gs232c_inst_queue_deq.sv
// Instruction queue dequeue controller: owns the head pointer, refills an
// M-lane registered decode buffer from the queue, and forwards flush as cancel.
module gs232c_inst_queue_deq
    import gs232c_iq_pkg::*;
#(
    parameter int unsigned W = IQ_W,
    parameter int unsigned N = IQ_N,
    parameter int unsigned M = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic [N+2:0]       tail,
    input  logic [W*M-1:0]     q_data,
    output logic [N+2:0]       head,
    output logic               cancel,
    output logic [M-1:0]       dec_valid,
    output logic [W*M-1:0]     dec_data,
    input  logic [1:0]         dec_accept,
    output logic [N+2:0]       occupancy,
    output logic               acc_err
);

    localparam int unsigned PW = ptr_width(N);

    logic [PW-1:0]  head_r;
    logic [PW-1:0]  occ;
    logic [M-1:0]   valid_r;
    logic [W*M-1:0] data_r;
    logic           err_r;

    logic [1:0]     cnt;
    logic [1:0]     acc_eff;
    logic [1:0]     rem;
    logic [1:0]     room;
    logic [1:0]     load;
    logic           err_now;
    logic [W*M-1:0] nxt_data;
    logic [M-1:0]   nxt_valid;

    // The wrap bit makes tail-head read 4<<N on a full queue rather than 0.
    assign occ       = tail - head_r;
    assign occupancy = occ;
    assign cancel    = flush;
    assign head      = head_r;
    assign dec_valid = valid_r;
    assign dec_data  = data_r;
    assign acc_err   = err_r;

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < M; i++) begin
            cnt = cnt + 2'(valid_r[i]);
        end
        err_now = (dec_accept > cnt);
        acc_eff = err_now ? cnt : dec_accept;
        rem     = cnt - acc_eff;
        room    = 2'(M) - rem;
        load    = ({{(PW-2){1'b0}}, room} < occ) ? room : occ[1:0];
    end

    gs232c_iq_lane_compact #(
        .W(W),
        .M(M)
    ) u_compact (
        .cur_data (data_r),
        .q_data   (q_data),
        .acc      (acc_eff),
        .rem      (rem),
        .load     (load),
        .nxt_data (nxt_data),
        .nxt_valid(nxt_valid)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_r  <= '0;
            valid_r <= '0;
            data_r  <= '0;
            err_r   <= 1'b0;
        end else if (flush) begin
            valid_r <= '0;
        end else begin
            head_r  <= head_r + {{(PW-2){1'b0}}, load};
            valid_r <= nxt_valid;
            data_r  <= nxt_data;
            if (err_now) err_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gs232c_inst_queue_deq.sv
// Directed bench for gs232c_inst_queue_deq (W=39, N=2, M=3); the queue is
// emulated by driving tail and presenting entry(ptr) on q_data lanes.
module tb_gs232c_inst_queue_deq;

    logic         clock = 1'b0;
    logic         reset;
    logic         flush;
    logic [4:0]   tail;
    logic [116:0] q_data;
    logic [4:0]   head;
    logic         cancel;
    logic [2:0]   dec_valid;
    logic [116:0] dec_data;
    logic [1:0]   dec_accept;
    logic [4:0]   occupancy;
    logic         acc_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    gs232c_inst_queue_deq #(.W(39), .N(2), .M(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .tail      (tail),
        .q_data    (q_data),
        .head      (head),
        .cancel    (cancel),
        .dec_valid (dec_valid),
        .dec_data  (dec_data),
        .dec_accept(dec_accept),
        .occupancy (occupancy),
        .acc_err   (acc_err)
    );

    function automatic logic [38:0] entry(input logic [4:0] p);
        return 39'h1000 + 39'(p);
    endfunction

    always_comb begin
        q_data = '0;
        for (int i = 0; i < 3; i++) q_data[i*39 +: 39] = entry(head + 5'(i));
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; tail = 5'd0; dec_accept = 2'd0;
        step(); step();
        n_cmp++; if (head !== 5'd0) begin n_err++; $display("FAIL reset_head got %0d want 0", head); end
        n_cmp++; if (dec_valid !== 3'b000) begin n_err++; $display("FAIL reset_valid got %b want 000", dec_valid); end
        n_cmp++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        n_cmp++; if (acc_err !== 1'b0) begin n_err++; $display("FAIL reset_acc_err got %b want 0", acc_err); end
        n_cmp++; if (dec_data !== 117'd0) begin n_err++; $display("FAIL reset_data got %h want 0", dec_data); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_burst();
        tail = 5'd5;
        #1;
        n_cmp++; if (occupancy !== 5'd5) begin n_err++; $display("FAIL burst_occ_pre got %0d want 5", occupancy); end
        step();
        n_cmp++; if (dec_valid !== 3'b111) begin n_err++; $display("FAIL burst_valid got %b want 111", dec_valid); end
        n_cmp++; if (head !== 5'd3) begin n_err++; $display("FAIL burst_head got %0d want 3", head); end
        n_cmp++; if (occupancy !== 5'd2) begin n_err++; $display("FAIL burst_occ got %0d want 2", occupancy); end
        n_cmp++; if (dec_data !== {39'h1002, 39'h1001, 39'h1000}) begin n_err++; $display("FAIL burst_data got %h want lanes 1000,1001,1002", dec_data); end
        step();
        n_cmp++; if (head !== 5'd3) begin n_err++; $display("FAIL stall_head got %0d want 3", head); end
        n_cmp++; if (dec_valid !== 3'b111) begin n_err++; $display("FAIL stall_valid got %b want 111", dec_valid); end
    endtask

    task automatic test_drain();
        logic [4:0] exp_head;
        exp_head = 5'd3;
        dec_accept = 2'd3;
        for (int k = 0; k < 10; k++) begin
            tail = tail + 5'd3;
            #1;
            n_cmp++; if (occupancy !== 5'd5) begin n_err++; $display("FAIL drain_occ_pre[%0d] got %0d want 5", k, occupancy); end
            step();
            exp_head = exp_head + 5'd3;
            n_cmp++; if (head !== exp_head) begin n_err++; $display("FAIL drain_head[%0d] got %0d want %0d", k, head, exp_head); end
            n_cmp++; if (dec_valid !== 3'b111) begin n_err++; $display("FAIL drain_valid[%0d] got %b want 111", k, dec_valid); end
            n_cmp++; if (occupancy !== 5'd2) begin n_err++; $display("FAIL drain_occ[%0d] got %0d want 2", k, occupancy); end
            n_cmp++; if (dec_data[38:0] !== entry(exp_head - 5'd3)) begin n_err++; $display("FAIL drain_lane0[%0d] got %h want %h", k, dec_data[38:0], entry(exp_head - 5'd3)); end
        end
        dec_accept = 2'd0;
    endtask

    task automatic test_partial();
        // buffer holds entries 30,31,0; head=1
        tail = 5'd2;
        dec_accept = 2'd1;
        step();
        dec_accept = 2'd0;
        n_cmp++; if (dec_data !== {39'h1001, 39'h1000, 39'h101F}) begin n_err++; $display("FAIL partial_data got %h want lanes 101f,1000,1001", dec_data); end
        n_cmp++; if (dec_valid !== 3'b111) begin n_err++; $display("FAIL partial_valid got %b want 111", dec_valid); end
        n_cmp++; if (head !== 5'd2) begin n_err++; $display("FAIL partial_head got %0d want 2", head); end
        n_cmp++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL partial_occ got %0d want 0", occupancy); end
    endtask

    task automatic test_flush();
        tail = 5'd9;
        flush = 1'b1;
        dec_accept = 2'd2;
        #1;
        n_cmp++; if (cancel !== 1'b1) begin n_err++; $display("FAIL flush_cancel got %b want 1", cancel); end
        n_cmp++; if (occupancy !== 5'd7) begin n_err++; $display("FAIL flush_occ_pre got %0d want 7", occupancy); end
        step();
        tail = 5'd2;
        flush = 1'b0;
        dec_accept = 2'd0;
        #1;
        n_cmp++; if (dec_valid !== 3'b000) begin n_err++; $display("FAIL flush_valid got %b want 000", dec_valid); end
        n_cmp++; if (head !== 5'd2) begin n_err++; $display("FAIL flush_head got %0d want 2", head); end
        n_cmp++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL flush_occ got %0d want 0", occupancy); end
        n_cmp++; if (cancel !== 1'b0) begin n_err++; $display("FAIL flush_cancel_off got %b want 0", cancel); end
        n_cmp++; if (acc_err !== 1'b0) begin n_err++; $display("FAIL flush_acc_err got %b want 0", acc_err); end
    endtask

    task automatic test_empty();
        step();
        n_cmp++; if (dec_valid !== 3'b000) begin n_err++; $display("FAIL empty_valid got %b want 000", dec_valid); end
        n_cmp++; if (head !== 5'd2) begin n_err++; $display("FAIL empty_head got %0d want 2", head); end
    endtask

    task automatic test_illegal_accept();
        tail = 5'd3;
        step();
        n_cmp++; if (dec_valid !== 3'b001) begin n_err++; $display("FAIL ill_setup_valid got %b want 001", dec_valid); end
        n_cmp++; if (dec_data[38:0] !== 39'h1002) begin n_err++; $display("FAIL ill_setup_lane0 got %h want 1002", dec_data[38:0]); end
        dec_accept = 2'd2;
        step();
        dec_accept = 2'd0;
        n_cmp++; if (acc_err !== 1'b1) begin n_err++; $display("FAIL ill_acc_err got %b want 1", acc_err); end
        n_cmp++; if (dec_valid !== 3'b000) begin n_err++; $display("FAIL ill_valid got %b want 000", dec_valid); end
        n_cmp++; if (head !== 5'd3) begin n_err++; $display("FAIL ill_head got %0d want 3", head); end
        step();
        n_cmp++; if (acc_err !== 1'b1) begin n_err++; $display("FAIL ill_sticky got %b want 1", acc_err); end
    endtask

    task automatic test_full();
        tail = 5'd19;
        #1;
        n_cmp++; if (occupancy !== 5'd16) begin n_err++; $display("FAIL full_occ got %0d want 16", occupancy); end
        step();
        n_cmp++; if (head !== 5'd6) begin n_err++; $display("FAIL full_head got %0d want 6", head); end
        n_cmp++; if (dec_valid !== 3'b111) begin n_err++; $display("FAIL full_valid got %b want 111", dec_valid); end
        n_cmp++; if (occupancy !== 5'd13) begin n_err++; $display("FAIL full_occ_after got %0d want 13", occupancy); end
        n_cmp++; if (dec_data !== {39'h1005, 39'h1004, 39'h1003}) begin n_err++; $display("FAIL full_data got %h want lanes 1003,1004,1005", dec_data); end
    endtask

    task automatic test_async_reset();
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (head !== 5'd0) begin n_err++; $display("FAIL areset_head got %0d want 0", head); end
        n_cmp++; if (dec_valid !== 3'b000) begin n_err++; $display("FAIL areset_valid got %b want 000", dec_valid); end
        n_cmp++; if (acc_err !== 1'b0) begin n_err++; $display("FAIL areset_acc_err got %b want 0", acc_err); end
        n_cmp++; if (dec_data !== 117'd0) begin n_err++; $display("FAIL areset_data got %h want 0", dec_data); end
        tail = 5'd0;
        step();
        reset = 1'b1;
        #1;
        n_cmp++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL areset_occ got %0d want 0", occupancy); end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_drain();
        test_partial();
        test_flush();
        test_empty();
        test_illegal_accept();
        test_full();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gs232c_inst_queue_deq.md
# gs232c_inst_queue_deq

Dequeue controller on the read side of the instruction queue. It owns the queue head pointer and tracks occupancy against the queue tail. It loads up to M instructions per cycle into a registered decode-facing buffer and retires them as decode accepts them. Front-end flush is forwarded to the queue as its cancel and clears the decode buffer.

## Interface
Parameters:
- W, 39, instruction entry width in bits.
- N, 2, queue bank-depth log2; queue capacity 4<<N entries; pointer width N+3.
- M, 3, decode lanes; legal values 1..3.

Ports:
- clock  in  1  sole clock; all state on posedge.
- reset  in  1  asynchronous, active-low; state cleared while 0.
- flush  in  1  front-end redirect; discards all queued and buffered instructions.
- tail  in  N+3  queue tail pointer.
- q_data  in  W*M  queue read lanes; lane i is entry head+i.
- head  out  N+3  queue head pointer; registered.
- cancel  out  1  queue cancel; combinational copy of flush.
- dec_valid  out  M  decode lane valids; thermometer, lane 0 oldest; registered.
- dec_data  out  W*M  decode lane data; registered.
- dec_accept  in  2  lanes decode consumes this cycle, always from lane 0; legal range 0..popcount(dec_valid).
- occupancy  out  N+3  entries in the queue, tail-head; combinational.
- acc_err  out  1  sticky; dec_accept exceeded popcount(dec_valid).

## Operation
- occupancy = (tail - head) mod 2^(N+3); range 0..4<<N.
- cnt = popcount(dec_valid).
- rem = cnt - min(dec_accept, cnt).
- load = min(M - rem, occupancy).
- Next buffer:
  - Lanes 0..rem-1 take old lanes dec_accept..dec_accept+rem-1 (shift down by accept).
  - Lanes rem..rem+load-1 take q_data lanes 0..load-1.
  - dec_valid next = (1<<(rem+load))-1.
- head next = head + load, mod 2^(N+3). Entries in dec_data are already removed from the queue.
- Invalid lanes keep their data register value unchanged; their content is don't-care.
- Flush has priority over everything:
  - dec_valid becomes 0.
  - head holds.
  - cancel=1 in the same cycle, so the queue sets tail to head at the same edge.
  - Any accept in the flush cycle is ignored.
- acc_err sets when dec_accept > cnt with flush=0. On error, the buffer behaves as if dec_accept = cnt. Only reset clears acc_err.
- No state machine beyond the buffer: buffer states are counts 0..M.

## Timing
- Reset values: head=0, dec_valid=0, dec_data=0, acc_err=0.
- cancel and occupancy are combinational; all other outputs are registered.
- Queue push at edge k makes tail visible in cycle k. The entry is in dec_data with valid at edge k+1. Push-to-decode latency is 1 cycle.
- Accept and refill in the same cycle: a full buffer with accept=M and occupancy≥M reloads M lanes. This sustains M per cycle.
- Empty queue (occupancy=0): load=0; head holds; the buffer only drains.
- Full queue (occupancy=4<<N): occupancy must read 16 for N=2, not 0. This depends on the wrap bit.
- Wrap-around: head passing 2^(N+3)-1 rolls to 0. occupancy stays correct across the wrap.
- Reset asserted mid-stream: immediate clear to reset values, regardless of clock.
- Flush and tail changes in the same cycle: flush wins; tail input is ignored for load.

## Structure
- Shared package gs232c_iq_pkg holds:
  - W default.
  - Pointer-width constant N+3.
  - Capacity constant 4<<N.
- One sub-module, gs232c_iq_lane_compact: the combinational merge of shifted remaining lanes and new queue lanes, parameterised by W and M.
- The top level holds the head register, occupancy subtraction, load/rem arithmetic, flush and acc_err logic.

## Test plan
- Reset then idle, tail=0:
  - head=0, dec_valid=000, occupancy=0, acc_err=0.
- Burst: tail steps to 5, dec_accept=0:
  - Next edge: dec_valid=111, head=3, occupancy=2.
  - Then stalls: head stays 3.
- Steady drain, occupancy=2, dec_accept=3 each cycle with tail advancing 3 per cycle:
  - dec_valid stays 111; head advances 3 per cycle.
  - Across head 30→1 wrap, occupancy is correct.
- Partial accept: dec_valid=111, dec_accept=1, occupancy=1:
  - Next edge: old lanes 1,2 move to lanes 0,1 and q_data lane 0 goes to lane 2.
  - head+=1.
- Flush with dec_valid=111, occupancy=7:
  - cancel=1 that cycle.
  - Next edge: dec_valid=000, head unchanged, queue tail=head, occupancy=0.
- Illegal accept: dec_valid=001, dec_accept=2:
  - acc_err=1 next edge and stays 1 until reset.
  - The buffer drains as accept=1.
